// File: rtl/input_event_queue.sv
// input_event_queue: snapshots the joystick channels and timestamp on a sample
// strobe, scans one channel per cycle, and queues a timestamped record for
// every channel whose value moved since it was last reported. Records are
// held in a first-word-fall-through FIFO drained through valid/ready.
module input_event_queue #(
  parameter  int CHANNELS = 6,
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int TS_WIDTH = 33,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] joystick,
  input  logic [TS_WIDTH-1:0]       timestamp,
  input  logic                      sample_en,
  input  logic                      clear,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [CW-1:0]             evt_channel,
  output logic [WIDTH-1:0]          evt_data,
  output logic [TS_WIDTH-1:0]       evt_ts,
  output logic [AW:0]               count,
  output logic                      busy,
  output logic                      overflow,
  output logic [15:0]               drop_count
);

  localparam int EW = CW + WIDTH + TS_WIDTH;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_idx;
  logic [WIDTH-1:0]    r_snap [CHANNELS];
  logic [WIDTH-1:0]    r_last [CHANNELS];
  logic [TS_WIDTH-1:0] r_snap_ts;

  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic                r_overflow;
  logic [15:0]         r_drop;

  logic                w_scan;
  logic                w_full;
  logic                w_diff;
  logic                w_push;
  logic                w_refuse;
  logic                w_pop;

  assign w_scan   = (r_state == S_SCAN);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_diff   = (r_snap[r_idx] != r_last[r_idx]);
  // Fullness uses the registered count, so a same-cycle pop never frees room
  // for the push being evaluated.
  assign w_push   = !clear && w_scan && w_diff && !w_full;
  assign w_refuse = !clear && w_scan && w_diff && w_full;
  assign w_pop    = !clear && (r_count != '0) && evt_ready;

  // Scanner: capture snapshot in IDLE, walk the channels in SCAN.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_snap_ts <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_snap[i] <= '0;
        r_last[i] <= '0;
      end
    end else if (clear) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) r_last[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sample_en) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
              r_snap[i] <= joystick[i*WIDTH +: WIDTH];
            r_snap_ts <= timestamp;
            r_idx     <= '0;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          // A refused change leaves last[] stale so it is re-reported later.
          if (w_push) r_last[r_idx] <= r_snap[r_idx];
          if (r_idx == CW'(CHANNELS - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; zeroed on reset so the head reads 0 before any push.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= {r_idx, r_snap[r_idx], r_snap_ts};
    end
  end

  // FIFO pointers, occupancy, and drop accounting.
  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_refuse) begin
        r_overflow <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign evt_valid = (r_count != '0);
  assign {evt_channel, evt_data, evt_ts} = r_mem[r_rptr];
  assign count      = r_count;
  assign busy       = w_scan;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_input_event_queue.sv
// Bench for input_event_queue (CHANNELS=6, DEPTH=4): table of sample vectors
// with expected occupancy/overflow/drop counts, a scoreboard of expected
// events checked as the consumer pops, and hand sequences for timing corners.
module tb_input_event_queue;

  localparam int CHANNELS = 6;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int TS_WIDTH = 33;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] joystick;
  logic [TS_WIDTH-1:0]       timestamp;
  logic                      sample_en;
  logic                      clear;
  logic                      evt_valid;
  logic                      evt_ready;
  logic [2:0]                evt_channel;
  logic [WIDTH-1:0]          evt_data;
  logic [TS_WIDTH-1:0]       evt_ts;
  logic [2:0]                count;
  logic                      busy;
  logic                      overflow;
  logic [15:0]               drop_count;

  input_event_queue #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TS_WIDTH(TS_WIDTH)
  ) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .joystick   (joystick),
    .timestamp  (timestamp),
    .sample_en  (sample_en),
    .clear      (clear),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_channel(evt_channel),
    .evt_data   (evt_data),
    .evt_ts     (evt_ts),
    .count      (count),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]          ch;
    logic [WIDTH-1:0]    data;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  typedef struct {
    logic [CHANNELS*WIDTH-1:0] joy;
    bit                        drain;
    int                        cnt;
    bit                        ovf;
    int                        drop;
  } vec_t;

  evt_t             sb [$];
  logic [WIDTH-1:0] mlast [CHANNELS];
  int               total = 0;
  int               bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle: advance past the edge, then move the timestamp in the drive window.
  task automatic step();
    @(posedge clk);
    #1;
    timestamp = timestamp + 1'b1;
  endtask

  // Reference for a sample with no consumer activity during the scan.
  task automatic model_sample(input logic [TS_WIDTH-1:0] ts);
    evt_t e;
    logic [WIDTH-1:0] d;
    for (int k = 0; k < CHANNELS; k++) begin
      d = joystick[k*WIDTH +: WIDTH];
      if (d != mlast[k] && sb.size() < DEPTH) begin
        e.ch = 3'(k);
        e.data = d;
        e.ts = ts;
        sb.push_back(e);
        mlast[k] = d;
      end
    end
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  task automatic drain();
    int exp_c;
    exp_c = sb.size();
    evt_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("drain_count", {61'd0, count}, exp_c);
      if (exp_c == 0) break;
      step();
      exp_c--;
    end
    step();
    check("ready_when_empty", {61'd0, count}, 0);
    evt_ready = 1'b0;
    check("sb_left", sb.size(), 0);
  endtask

  // Consumer-side scoreboard: every accepted head must match the oldest expectation.
  always @(negedge clk) begin : mon
    evt_t e;
    if (!reset && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got ch=%0d data=%0h want none", evt_channel, evt_data);
      end else begin
        e = sb.pop_front();
        check("evt_channel", {61'd0, evt_channel}, {61'd0, e.ch});
        check("evt_data", {32'd0, evt_data}, {32'd0, e.data});
        check("evt_ts", {31'd0, evt_ts}, {31'd0, e.ts});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    logic [TS_WIDTH-1:0] ts0;
    evt_t e;
    int nb;

    vecs[0] = '{joy: {32'h55555555, 32'h0, 32'h33333333, 32'h10, 32'h0, 32'h11111111},
                drain: 1'b1, cnt: 4, ovf: 1'b0, drop: 0};
    vecs[1] = '{joy: {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                drain: 1'b1, cnt: 4, ovf: 1'b1, drop: 2};
    vecs[2] = '{joy: {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                drain: 1'b0, cnt: 2, ovf: 1'b1, drop: 2};
    vecs[3] = '{joy: {32'hA5, 32'hA4, 32'hA3, 32'hB2, 32'hB1, 32'hB0},
                drain: 1'b0, cnt: 4, ovf: 1'b1, drop: 3};

    reset = 1'b1; clear = 1'b0; sample_en = 1'b0; evt_ready = 1'b0;
    joystick = '0; timestamp = 33'h1_FFFF_FFF0;
    for (int k = 0; k < CHANNELS; k++) mlast[k] = '0;
    repeat (3) step();
    reset = 1'b0;

    check("rst_valid", {63'd0, evt_valid}, 0);
    check("rst_count", {61'd0, count}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_overflow", {63'd0, overflow}, 0);
    check("rst_drop", {48'd0, drop_count}, 0);
    check("rst_channel", {61'd0, evt_channel}, 0);
    check("rst_data", {32'd0, evt_data}, 0);
    check("rst_ts", {31'd0, evt_ts}, 0);

    // Single change on channel 2: event appears exactly at T+4.
    joystick[2*WIDTH +: WIDTH] = 32'h10;
    ts0 = timestamp;
    pulse_sample();
    check("busy_t1", {63'd0, busy}, 1);
    step(); step();
    check("valid_t3", {63'd0, evt_valid}, 0);
    step();
    check("valid_t4", {63'd0, evt_valid}, 1);
    check("chan_t4", {61'd0, evt_channel}, 2);
    check("data_t4", {32'd0, evt_data}, 64'h10);
    check("ts_t4", {31'd0, evt_ts}, {31'd0, ts0});
    check("count_t4", {61'd0, count}, 1);
    e.ch = 3'd2; e.data = 32'h10; e.ts = ts0;
    sb.push_back(e);
    mlast[2] = 32'h10;
    step(); step(); step();
    check("busy_t7", {63'd0, busy}, 0);

    // Unchanged inputs: busy for exactly CHANNELS cycles, nothing queued.
    pulse_sample();
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) nb++;
      step();
    end
    check("busy_cycles", nb, CHANNELS);
    check("nochg_count", {61'd0, count}, 1);

    for (int v = 0; v < 4; v++) begin
      joystick = vecs[v].joy;
      model_sample(timestamp);
      pulse_sample();
      repeat (CHANNELS) step();
      check("vec_busy", {63'd0, busy}, 0);
      check("vec_count", {61'd0, count}, vecs[v].cnt);
      check("vec_overflow", {63'd0, overflow}, {63'd0, vecs[v].ovf});
      check("vec_drop", {48'd0, drop_count}, vecs[v].drop);
      if (vecs[v].drain) drain();
    end

    // Full FIFO with a pop in the refusing cycle: ch2 refused, ch3 accepted next cycle.
    joystick[3*WIDTH +: WIDTH] = 32'hB3;
    e.ch = 3'd3; e.data = 32'hB3; e.ts = timestamp;
    sb.push_back(e);
    mlast[3] = 32'hB3;
    pulse_sample();
    step(); step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("fullpop_count_t4", {61'd0, count}, 3);
    check("fullpop_drop_t4", {48'd0, drop_count}, 4);
    step();
    check("fullpop_count_t5", {61'd0, count}, 4);
    step(); step();
    check("fullpop_overflow", {63'd0, overflow}, 1);
    drain();

    // The refused channel 2 is reported by the next unchanged sample.
    model_sample(timestamp);
    pulse_sample();
    repeat (CHANNELS) step();
    check("retry_count", {61'd0, count}, 1);
    drain();

    // Clear in T+2 aborts the scan and drops the already-pushed channel 0 record.
    joystick[0 +: WIDTH] = 32'hC0;
    pulse_sample();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_busy", {63'd0, busy}, 0);
    check("clr_count", {61'd0, count}, 0);
    check("clr_overflow", {63'd0, overflow}, 0);
    check("clr_drop", {48'd0, drop_count}, 0);
    for (int k = 0; k < CHANNELS; k++) mlast[k] = '0;
    model_sample(timestamp);
    pulse_sample();
    check("clr_resample_busy", {63'd0, busy}, 1);
    repeat (CHANNELS) step();
    check("clr_resample_count", {61'd0, count}, 4);
    check("clr_resample_overflow", {63'd0, overflow}, 1);
    check("clr_resample_drop", {48'd0, drop_count}, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_event_queue.md
# input_event_queue

Parametrised input-change capture block for the input test core. It snapshots all joystick channels and the HPS timestamp on a sample strobe, then scans the channels one per cycle. Each channel whose value differs from its last reported value is pushed into a first-word-fall-through event FIFO. The FIFO is drained by the test CPU through a valid/ready port. This replaces continuous polling of the raw joystick buses with timestamped, lossless-or-flagged change records.

## Interface
Parameters:
- CHANNELS, 6: number of input channels (1..16).
- WIDTH, 32: bits per channel.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- TS_WIDTH, 33: timestamp width.
- Derived: CW = max(1, clog2(CHANNELS)); AW = clog2(DEPTH).

Ports:
- clk_sys  in  1: system clock; all logic is in this one domain.
- reset  in  1: synchronous, active-high reset.
- joystick  in  CHANNELS*WIDTH: packed channels; channel 0 is in [WIDTH-1:0].
- timestamp  in  TS_WIDTH: free-running timestamp.
- sample_en  in  1: single-cycle sample strobe.
- clear  in  1: synchronous flush.
- evt_valid  out  1: FIFO head is valid.
- evt_ready  in  1: consumer accepts the head.
- evt_channel  out  CW: channel index of the head event.
- evt_data  out  WIDTH: new channel value of the head event.
- evt_ts  out  TS_WIDTH: snapshot timestamp of the head event.
- count  out  AW+1: FIFO occupancy.
- busy  out  1: high while the scanner is in SCAN.
- overflow  out  1: sticky; set when an event was refused because the FIFO was full.
- drop_count  out  16: refused events, saturating at 16'hFFFF.

## Operation
- Scanner FSM has two states, IDLE and SCAN.
- IDLE, sample_en=1: latch all channels into snap[], latch timestamp into snap_ts, set idx=0, go to SCAN.
- SCAN, each cycle: compare snap[idx] with last[idx].
  - Equal: no action.
  - Differ and FIFO not full: push {idx, snap[idx], snap_ts}; last[idx] <= snap[idx].
  - Differ and FIFO full: no push. last[idx] is unchanged, so the change is reported again on a later sample. Set overflow; increment drop_count (saturating).
  - idx == CHANNELS-1: go to IDLE; otherwise idx+1.
- sample_en in SCAN is ignored; it is neither queued nor counted.
- Fullness is evaluated on the registered count at the start of the cycle. A push is refused when full even if a pop happens in the same cycle.
- Pop occurs when evt_valid && evt_ready. Push and pop in the same cycle leave count unchanged. evt_ready while empty has no effect.
- FIFO is a circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0. evt_* show the entry at the read pointer (FWFT). evt_* are don't-care while evt_valid=0.
- clear: empties the FIFO, clears overflow and drop_count, sets every last[] to 0, and forces the FSM to IDLE (aborts any scan). clear has priority over sample_en, push and pop.
- reset: same effect as clear. It also zeroes snap[] and snap_ts.
- Because last[] starts at 0, every nonzero channel produces an event on the first sample after reset or clear.

## Timing
- Reset values: evt_valid=0, count=0, busy=0, overflow=0, drop_count=0. evt_channel, evt_data and evt_ts are 0 after reset.
- Cycle numbering, with sample_en high in cycle T:
  - Snapshot is captured at the end of T.
  - Channel k is compared in cycle T+1+k.
  - Its event is visible on evt_* in cycle T+2+k.
- Latency from sample_en to the first possible evt_valid is 2 cycles.
- busy is high in cycles T+1 through T+CHANNELS. The next sample_en is accepted in cycle T+1+CHANNELS.
- A pop in cycle P presents the next entry in cycle P+1. count and evt_valid update at the same edge.
- overflow and drop_count update at the end of the refusing cycle.

## Test plan
- Basic change: after reset, channels all 0; set channel 2 to 0x00000010 and pulse sample_en at T (evt_ready=0) -> exactly one event, in cycle T+4: channel=2, data=0x10, ts=timestamp at T. count=1.
- No-change sample: repeat sample_en with the inputs unchanged -> no new events; count stays 1; busy is high for 6 cycles.
- Multi-channel ordering: change channels 5, 0 and 3 together and sample -> events in channel order 0, 3, 5, all with the same ts. Drain with evt_ready=1 -> count decrements by 1 per cycle to 0.
- Overflow: DEPTH=4, all 6 channels change, evt_ready=0 -> 4 events queued; overflow=1, drop_count=2. Drain, then sample again with inputs unchanged -> channels 4 and 5 are reported.
- Full plus simultaneous pop: FIFO full with evt_ready=1 during a scan that has a changed channel -> the push is refused and drop_count increments. Pushes resume in the cycle after count < DEPTH.
- Clear mid-scan: assert clear in cycle T+2 -> in the next cycle busy=0, count=0, overflow=0, drop_count=0. The following sample reports every nonzero channel.
